// File: rtl/branch_predict_unit_if.sv
// Resolve/predict bus between the ALU stage, fetch and the branch predict unit.
interface branch_predict_unit_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH  = 16
);
  // Predict side
  logic [PC_WIDTH-1:0]   fetch_pc_pi;
  logic                  predict_taken_po;
  // Resolve side
  logic                  resolve_valid_pi;
  logic [PC_WIDTH-1:0]   resolve_pc_pi;
  logic [2:0]            branch_cond_pi;
  logic [DATA_WIDTH-1:0] reg1_data_pi;
  logic [DATA_WIDTH-1:0] reg2_data_pi;
  logic                  alu_carry_bit_pi;
  logic                  predicted_taken_pi;
  logic                  resolve_done_po;
  logic                  is_branch_taken_po;
  logic                  mispredict_po;
  logic [CNT_WIDTH-1:0]  branch_count_po;
  logic [CNT_WIDTH-1:0]  mispredict_count_po;

  modport master (
    output fetch_pc_pi, resolve_valid_pi, resolve_pc_pi, branch_cond_pi,
           reg1_data_pi, reg2_data_pi, alu_carry_bit_pi, predicted_taken_pi,
    input  predict_taken_po, resolve_done_po, is_branch_taken_po, mispredict_po,
           branch_count_po, mispredict_count_po
  );

  modport slave (
    input  fetch_pc_pi, resolve_valid_pi, resolve_pc_pi, branch_cond_pi,
           reg1_data_pi, reg2_data_pi, alu_carry_bit_pi, predicted_taken_pi,
    output predict_taken_po, resolve_done_po, is_branch_taken_po, mispredict_po,
           branch_count_po, mispredict_count_po
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution (condition compare) plus a direct-mapped PHT of 2-bit
// saturating counters feeding fetch, with saturating branch/mispredict stats.
module branch_predict_unit #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned PHT_IDX_BITS = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic               clk_pi,
  input logic               reset_pi,
  branch_predict_unit_if.slave bp_if
);

  localparam int unsigned PhtEntries = 1 << PHT_IDX_BITS;

  localparam logic [2:0] CondEq     = 3'b000;
  localparam logic [2:0] CondNe     = 3'b001;
  localparam logic [2:0] CondGeu    = 3'b010;
  localparam logic [2:0] CondLeu    = 3'b011;
  localparam logic [2:0] CondGes    = 3'b100;
  localparam logic [2:0] CondLts    = 3'b101;
  localparam logic [2:0] CondCarry  = 3'b110;
  localparam logic [2:0] CondAlways = 3'b111;

  logic [1:0]              pht_q [PhtEntries];
  logic [1:0]              pht_entry_d;
  logic [PHT_IDX_BITS-1:0] fetch_idx;
  logic [PHT_IDX_BITS-1:0] resolve_idx;
  logic                    taken;
  logic                    resolve_done_q, resolve_done_d;
  logic                    is_taken_q, is_taken_d;
  logic                    mispredict_q, mispredict_d;
  logic [CNT_WIDTH-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]    mispredict_cnt_q, mispredict_cnt_d;

  assign fetch_idx   = bp_if.fetch_pc_pi[PHT_IDX_BITS-1:0];
  assign resolve_idx = bp_if.resolve_pc_pi[PHT_IDX_BITS-1:0];

  // Prediction reads current PHT state, so a same-cycle update shows up next cycle.
  assign bp_if.predict_taken_po = pht_q[fetch_idx][1];

  // Evaluate the branch condition on the two operands.
  always_comb begin
    taken = 1'b0;
    unique case (bp_if.branch_cond_pi)
      CondEq:     taken = (bp_if.reg1_data_pi == bp_if.reg2_data_pi);
      CondNe:     taken = (bp_if.reg1_data_pi != bp_if.reg2_data_pi);
      CondGeu:    taken = (bp_if.reg1_data_pi >= bp_if.reg2_data_pi);
      CondLeu:    taken = (bp_if.reg1_data_pi <= bp_if.reg2_data_pi);
      CondGes:    taken = ($signed(bp_if.reg1_data_pi) >= $signed(bp_if.reg2_data_pi));
      CondLts:    taken = ($signed(bp_if.reg1_data_pi) < $signed(bp_if.reg2_data_pi));
      CondCarry:  taken = bp_if.alu_carry_bit_pi;
      CondAlways: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

  // Next-state for the resolved PHT entry, result flags and saturating counters.
  always_comb begin
    pht_entry_d      = pht_q[resolve_idx];
    resolve_done_d   = 1'b0;
    mispredict_d     = 1'b0;
    is_taken_d       = is_taken_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bp_if.resolve_valid_pi) begin
      if (taken) begin
        if (pht_q[resolve_idx] != 2'd3) pht_entry_d = pht_q[resolve_idx] + 2'd1;
      end else begin
        if (pht_q[resolve_idx] != 2'd0) pht_entry_d = pht_q[resolve_idx] - 2'd1;
      end
      resolve_done_d = 1'b1;
      is_taken_d     = taken;
      mispredict_d   = taken ^ bp_if.predicted_taken_pi;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      if (mispredict_d && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State update; reset wins over a same-cycle resolve and clears all history.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      for (int i = 0; i < int'(PhtEntries); i++) pht_q[i] <= 2'b01;
      resolve_done_q   <= 1'b0;
      is_taken_q       <= 1'b0;
      mispredict_q     <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (bp_if.resolve_valid_pi) pht_q[resolve_idx] <= pht_entry_d;
      resolve_done_q   <= resolve_done_d;
      is_taken_q       <= is_taken_d;
      mispredict_q     <= mispredict_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bp_if.resolve_done_po     = resolve_done_q;
  assign bp_if.is_branch_taken_po  = is_taken_q;
  assign bp_if.mispredict_po       = mispredict_q;
  assign bp_if.branch_count_po     = branch_cnt_q;
  assign bp_if.mispredict_count_po = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: default build plus a CNT_WIDTH=4 build.
module tb_branch_predict_unit;

  logic clk;
  logic reset;
  logic reset4;
  int   vecs;
  int   errs;

  branch_predict_unit_if #(.DATA_WIDTH(16), .PC_WIDTH(16), .CNT_WIDTH(16)) bp_if ();
  branch_predict_unit_if #(.DATA_WIDTH(16), .PC_WIDTH(16), .CNT_WIDTH(4))  bp4_if ();

  branch_predict_unit #(
    .DATA_WIDTH(16), .PC_WIDTH(16), .PHT_IDX_BITS(4), .CNT_WIDTH(16)
  ) u_dut (
    .clk_pi   (clk),
    .reset_pi (reset),
    .bp_if    (bp_if)
  );

  branch_predict_unit #(
    .DATA_WIDTH(16), .PC_WIDTH(16), .PHT_IDX_BITS(4), .CNT_WIDTH(4)
  ) u_dut4 (
    .clk_pi   (clk),
    .reset_pi (reset4),
    .bp_if    (bp4_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] pc, input logic [2:0] cond, input logic [15:0] r1,
                       input logic [15:0] r2, input logic carry, input logic pred);
    bp_if.resolve_valid_pi   = 1'b1;
    bp_if.resolve_pc_pi      = pc;
    bp_if.branch_cond_pi     = cond;
    bp_if.reg1_data_pi       = r1;
    bp_if.reg2_data_pi       = r2;
    bp_if.alu_carry_bit_pi   = carry;
    bp_if.predicted_taken_pi = pred;
  endtask

  task automatic idle();
    bp_if.resolve_valid_pi = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bp_if.fetch_pc_pi = 16'(i);
      #1;
      vecs++;
      if (bp_if.predict_taken_po !== 1'b0) begin
        errs++;
        $display("FAIL reset_predict pc=%0d got=%b exp=0", i, bp_if.predict_taken_po);
      end
    end
    vecs++;
    if (bp_if.branch_count_po !== 16'd0 || bp_if.mispredict_count_po !== 16'd0) begin
      errs++;
      $display("FAIL reset_counts got=%h/%h exp=0000/0000", bp_if.branch_count_po,
               bp_if.mispredict_count_po);
    end
    vecs++;
    if ({bp_if.resolve_done_po, bp_if.is_branch_taken_po, bp_if.mispredict_po} !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags got=%b%b%b exp=000", bp_if.resolve_done_po,
               bp_if.is_branch_taken_po, bp_if.mispredict_po);
    end
  endtask

  task automatic test_geu_train();
    do_reset();
    drive(16'h0023, 3'b010, 16'h8000, 16'h0001, 1'b0, 1'b0);
    step();
    idle();
    vecs++;
    if ({bp_if.resolve_done_po, bp_if.is_branch_taken_po, bp_if.mispredict_po} !== 3'b111) begin
      errs++;
      $display("FAIL geu_flags got=%b%b%b exp=111", bp_if.resolve_done_po,
               bp_if.is_branch_taken_po, bp_if.mispredict_po);
    end
    vecs++;
    if (bp_if.branch_count_po !== 16'd1 || bp_if.mispredict_count_po !== 16'd1) begin
      errs++;
      $display("FAIL geu_counts got=%0d/%0d exp=1/1", bp_if.branch_count_po,
               bp_if.mispredict_count_po);
    end
    step();
    vecs++;
    if ({bp_if.resolve_done_po, bp_if.is_branch_taken_po, bp_if.mispredict_po} !== 3'b010) begin
      errs++;
      $display("FAIL idle_flags got=%b%b%b exp=010", bp_if.resolve_done_po,
               bp_if.is_branch_taken_po, bp_if.mispredict_po);
    end
    drive(16'h0023, 3'b010, 16'h8000, 16'h0001, 1'b0, 1'b0);
    step();
    idle();
    bp_if.fetch_pc_pi = 16'h0003;
    #1;
    vecs++;
    if (bp_if.predict_taken_po !== 1'b1) begin
      errs++;
      $display("FAIL geu_predict got=%b exp=1", bp_if.predict_taken_po);
    end
    vecs++;
    if (bp_if.branch_count_po !== 16'd2 || bp_if.mispredict_count_po !== 16'd2) begin
      errs++;
      $display("FAIL geu_counts2 got=%0d/%0d exp=2/2", bp_if.branch_count_po,
               bp_if.mispredict_count_po);
    end
  endtask

  task automatic test_conditions();
    logic [2:0]  cond_t  [8] = '{3'b100, 3'b101, 3'b001, 3'b110, 3'b111, 3'b000, 3'b011, 3'b010};
    logic [15:0] r1_t    [8] = '{16'h8000, 16'h8000, 16'h1234, 16'h0000, 16'h0000,
                                 16'h5555, 16'hFFFF, 16'h0001};
    logic [15:0] r2_t    [8] = '{16'h0001, 16'h0001, 16'h1234, 16'h0000, 16'h0001,
                                 16'h5555, 16'h0001, 16'h0002};
    logic        carry_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_t   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(16'h0040 + 16'(i), cond_t[i], r1_t[i], r2_t[i], carry_t[i], 1'b0);
      step();
      vecs++;
      if (bp_if.is_branch_taken_po !== exp_t[i] || bp_if.mispredict_po !== exp_t[i]) begin
        errs++;
        $display("FAIL cond_%0d taken/mispredict got=%b/%b exp=%b/%b", cond_t[i],
                 bp_if.is_branch_taken_po, bp_if.mispredict_po, exp_t[i], exp_t[i]);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    bp_if.fetch_pc_pi = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      drive(16'h0005, 3'b111, 16'h0, 16'h0, 1'b0, 1'b1);
      step();
    end
    idle();
    vecs++;
    if (bp_if.predict_taken_po !== 1'b1) begin
      errs++;
      $display("FAIL sat_after5 got=%b exp=1", bp_if.predict_taken_po);
    end
    drive(16'h0005, 3'b000, 16'h0001, 16'h0002, 1'b0, 1'b1);
    step();
    vecs++;
    if (bp_if.predict_taken_po !== 1'b1) begin
      errs++;
      $display("FAIL sat_nt1 got=%b exp=1", bp_if.predict_taken_po);
    end
    step();
    idle();
    vecs++;
    if (bp_if.predict_taken_po !== 1'b0) begin
      errs++;
      $display("FAIL sat_nt2 got=%b exp=0", bp_if.predict_taken_po);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bp_if.fetch_pc_pi = 16'h0007;
    drive(16'h0107, 3'b111, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    vecs++;
    if (bp_if.predict_taken_po !== 1'b0) begin
      errs++;
      $display("FAIL bypass_same got=%b exp=0", bp_if.predict_taken_po);
    end
    step();
    idle();
    vecs++;
    if (bp_if.predict_taken_po !== 1'b1) begin
      errs++;
      $display("FAIL bypass_next got=%b exp=1", bp_if.predict_taken_po);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      // Even iterations taken (EQ on equal operands), odd not taken.
      drive(16'h0009, 3'b000, 16'h0010, (i % 2 == 0) ? 16'h0010 : 16'h0011, 1'b0, 1'b1);
      step();
      vecs++;
      if (bp_if.resolve_done_po !== 1'b1 || bp_if.is_branch_taken_po !== (i % 2 == 0)) begin
        errs++;
        $display("FAIL b2b_%0d done/taken got=%b/%b exp=1/%b", i, bp_if.resolve_done_po,
                 bp_if.is_branch_taken_po, (i % 2 == 0));
      end
    end
    idle();
    vecs++;
    if (bp_if.branch_count_po !== 16'd6 || bp_if.mispredict_count_po !== 16'd3) begin
      errs++;
      $display("FAIL b2b_counts got=%0d/%0d exp=6/3", bp_if.branch_count_po,
               bp_if.mispredict_count_po);
    end
  endtask

  task automatic test_cnt4();
    bp4_if.resolve_valid_pi = 1'b0;
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    bp4_if.fetch_pc_pi        = 16'h000A;
    bp4_if.resolve_pc_pi      = 16'h000A;
    bp4_if.branch_cond_pi     = 3'b111;
    bp4_if.reg1_data_pi       = 16'h0;
    bp4_if.reg2_data_pi       = 16'h0;
    bp4_if.alu_carry_bit_pi   = 1'b0;
    bp4_if.predicted_taken_pi = 1'b0;
    bp4_if.resolve_valid_pi   = 1'b1;
    for (int i = 0; i < 20; i++) step();
    vecs++;
    if (bp4_if.branch_count_po !== 4'hF || bp4_if.mispredict_count_po !== 4'hF) begin
      errs++;
      $display("FAIL cnt4_sat got=%h/%h exp=f/f", bp4_if.branch_count_po,
               bp4_if.mispredict_count_po);
    end
    vecs++;
    if (bp4_if.predict_taken_po !== 1'b1) begin
      errs++;
      $display("FAIL cnt4_trained got=%b exp=1", bp4_if.predict_taken_po);
    end
    // Resolve stays asserted across the reset cycle and must be dropped.
    reset4 = 1'b1;
    step();
    reset4 = 1'b0;
    bp4_if.resolve_valid_pi = 1'b0;
    #1;
    vecs++;
    if (bp4_if.resolve_done_po !== 1'b0 || bp4_if.mispredict_po !== 1'b0) begin
      errs++;
      $display("FAIL cnt4_rst_done got=%b/%b exp=0/0", bp4_if.resolve_done_po,
               bp4_if.mispredict_po);
    end
    vecs++;
    if (bp4_if.branch_count_po !== 4'h0 || bp4_if.mispredict_count_po !== 4'h0) begin
      errs++;
      $display("FAIL cnt4_rst_counts got=%h/%h exp=0/0", bp4_if.branch_count_po,
               bp4_if.mispredict_count_po);
    end
    vecs++;
    if (bp4_if.predict_taken_po !== 1'b0) begin
      errs++;
      $display("FAIL cnt4_rst_pht got=%b exp=0", bp4_if.predict_taken_po);
    end
    // Entry is back at 01: one taken resolve moves it to 10 and predicts taken.
    bp4_if.resolve_valid_pi = 1'b1;
    step();
    bp4_if.resolve_valid_pi = 1'b0;
    #1;
    vecs++;
    if (bp4_if.predict_taken_po !== 1'b1 || bp4_if.branch_count_po !== 4'h1) begin
      errs++;
      $display("FAIL cnt4_after_rst got=%b/%h exp=1/1", bp4_if.predict_taken_po,
               bp4_if.branch_count_po);
    end
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    reset = 1'b1;
    reset4 = 1'b1;
    bp_if.fetch_pc_pi        = '0;
    bp_if.resolve_valid_pi   = 1'b0;
    bp_if.resolve_pc_pi      = '0;
    bp_if.branch_cond_pi     = '0;
    bp_if.reg1_data_pi       = '0;
    bp_if.reg2_data_pi       = '0;
    bp_if.alu_carry_bit_pi   = 1'b0;
    bp_if.predicted_taken_pi = 1'b0;
    bp4_if.fetch_pc_pi        = '0;
    bp4_if.resolve_valid_pi   = 1'b0;
    bp4_if.resolve_pc_pi      = '0;
    bp4_if.branch_cond_pi     = '0;
    bp4_if.reg1_data_pi       = '0;
    bp4_if.reg2_data_pi       = '0;
    bp4_if.alu_carry_bit_pi   = 1'b0;
    bp4_if.predicted_taken_pi = 1'b0;
    test_reset();
    test_geu_train();
    test_conditions();
    test_saturation();
    test_same_cycle();
    test_back_to_back();
    test_cnt4();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
